// File: rtl/dcp_tx_fmt.sv
// dcp_tx_fmt - transmit formatter and 8N1 UART serializer for the debug
// command processors.
//
// A byte request (type_tx=0) sends din_tx[7:0] as one raw character.
// A word request (type_tx=1) sends din_tx as eight uppercase hex ASCII
// characters, most significant nibble first. Characters go back to back
// on the line. ack_tx pulses for one cycle once the last stop bit has
// finished. busy stays high until the requester releases req_tx.
//
// Optional feature macro: DCP_TX_SPACE_EN
//   defined   -> word mode appends an ASCII space (0x20), 9 characters/word
//   undefined -> word mode sends exactly 8 characters
//
// Parameters:
//   CLK_FREQ  clock frequency in Hz
//   BAUD      line rate; DIV = CLK_FREQ/BAUD cycles per bit (DIV >= 2)
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   req_tx   in   level request, held until ack_tx is seen
//   type_tx  in   0 = raw byte, 1 = hex word
//   din_tx   in   32-bit payload (byte mode uses [7:0])
//   ack_tx   out  one-cycle completion pulse
//   tx       out  UART line, idle high
//   busy     out  high from accept until the handshake is released
module dcp_tx_fmt #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] din_tx,
  output logic        ack_tx,
  output logic        tx,
  output logic        busy
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(DIV - 1);

`ifdef DCP_TX_SPACE_EN
  localparam logic [3:0] WORD_LAST = 4'd8;
`else
  localparam logic [3:0] WORD_LAST = 4'd7;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    char_q, char_d;
  logic          mode_q, mode_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

  // Character table for word mode; slot 8 is the optional trailing space.
  logic [7:0] word_chars [0:8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hex
      assign word_chars[gi] = hex_ascii(data_q[31-4*gi -: 4]);
    end
  endgenerate
  assign word_chars[8] = 8'h20;

  logic       timer_last;
  logic [3:0] last_idx;
  logic [3:0] sel_idx;
  logic [7:0] sel_char;

  assign timer_last = (timer_q == TIMER_LAST);
  assign last_idx   = mode_q ? WORD_LAST : 4'd0;

  // During the last stop-bit cycle the following character is selected,
  // so the next start bit follows the stop bit with no gap.
  assign sel_idx = (state_q == S_STOP) ? (char_q + 4'd1) : char_q;

  always_comb begin
    sel_char = data_q[7:0];
    if (mode_q) begin
      sel_char = (sel_idx > 4'd8) ? 8'h20 : word_chars[sel_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    char_d  = char_q;
    mode_d  = mode_q;
    data_d  = data_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    tx_d    = 1'b1;
    ack_d   = 1'b0;

    // Line and ack are registered from the current state, so they trail the
    // state by one cycle: the start bit appears two cycles after accept.
    case (state_q)
      S_START: tx_d  = 1'b0;
      S_DATA:  tx_d  = shreg_q[0];
      S_ACK:   ack_d = 1'b1;
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req_tx) begin
          mode_d  = type_tx;
          data_d  = din_tx;
          busy_d  = 1'b1;
          char_d  = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d = sel_char;
        timer_d = '0;
        state_d = S_START;
      end
      S_START: begin
        timer_d = timer_last ? '0 : timer_q + 1'b1;
        if (timer_last) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        timer_d = timer_last ? '0 : timer_q + 1'b1;
        if (timer_last) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        timer_d = timer_last ? '0 : timer_q + 1'b1;
        if (timer_last) begin
          if (char_q >= last_idx) begin
            state_d = S_ACK;
          end else begin
            char_d  = char_q + 4'd1;
            shreg_d = sel_char;
            state_d = S_START;
          end
        end
      end
      S_ACK: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Holding here until req_tx drops stops a still-high request from
        // re-triggering a second frame.
        if (!req_tx) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= 3'd0;
      char_q  <= 4'd0;
      mode_q  <= 1'b0;
      data_q  <= 32'd0;
      shreg_q <= 8'd0;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign tx     = tx_q;
  assign ack_tx = ack_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_dcp_tx_fmt.sv
// Directed testbench for dcp_tx_fmt with DIV = 10 (1 MHz clock, 100 kbaud).
module tb_dcp_tx_fmt;

`ifdef DCP_TX_SPACE_EN
  localparam int WCH = 9;
`else
  localparam int WCH = 8;
`endif
  localparam int HMAX = 1200;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] din_tx;
  logic        ack_tx;
  logic        tx;
  logic        busy;

  dcp_tx_fmt #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_tx (req_tx),
    .type_tx(type_tx),
    .din_tx (din_tx),
    .ack_tx (ack_tx),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Per-transaction capture, indexed by cycles after the accept edge.
  logic tx_hist [0:HMAX-1];
  int   ack_k, ack_cnt, req_drop_k, busy_fall_k, first_low_k, t0_abs;
  logic busy_k1;

  typedef struct {
    logic            typ;
    logic [31:0]     din;
    int              change_at;
    logic [31:0]     din2;
    int              hold;
    int              nchar;
    logic [0:8][7:0] exp;
    int              exp_ack;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+#1. Raises req, captures the line for every cycle,
  // drops req `hold` cycles after ack, ends `tail` cycles after busy falls.
  task automatic do_xfer(input logic typ, input logic [31:0] d, input int change_at,
                         input logic [31:0] d2, input int hold, input int tail);
    int k;
    type_tx = typ;
    din_tx  = d;
    req_tx  = 1'b1;
    ack_k = -1; ack_cnt = 0; req_drop_k = -1; busy_fall_k = -1; first_low_k = -1;
    busy_k1 = 1'b0;
    for (int i = 0; i < HMAX; i++) tx_hist[i] = 1'b1;
    @(posedge clk);
    #1;
    t0_abs = cyc;
    k = 0;
    while (k < HMAX - 1) begin
      k++;
      @(posedge clk);
      #1;
      tx_hist[k] = tx;
      if (k == 1) busy_k1 = busy;
      if (k == change_at) din_tx = d2;
      if (tx === 1'b0 && first_low_k < 0) first_low_k = k;
      if (ack_tx === 1'b1) begin
        ack_cnt++;
        if (ack_k < 0) ack_k = k;
      end
      if (ack_k >= 0 && req_tx && k == ack_k + hold) begin
        req_tx     = 1'b0;
        req_drop_k = k;
      end
      if (req_drop_k >= 0 && k > req_drop_k && busy === 1'b0 && busy_fall_k < 0) busy_fall_k = k;
      if (busy_fall_k >= 0 && k >= busy_fall_k + tail) break;
    end
    req_tx = 1'b0;
    $display("[TB] xfer type=%0d din=%h ack_at=%0d acks=%0d busy_fall=%0d", typ, d, ack_k, ack_cnt, busy_fall_k);
  endtask

  task automatic verify(input string tag, input int nchar, input logic [0:8][7:0] exp, input int exp_ack);
    int   base, lows;
    logic ok;
    logic [7:0] ch;
    chk({tag, "_busy_after_accept"}, {31'd0, busy_k1}, 32'd1);
    chk({tag, "_tx_idle_k1"}, {31'd0, tx_hist[1]}, 32'd1);
    chk({tag, "_start_at_k2"}, {31'd0, tx_hist[2]}, 32'd0);
    for (int c = 0; c < nchar; c++) begin
      base = 2 + c * 100;
      ok = (tx_hist[base + 5] === 1'b0) && (tx_hist[base + 95] === 1'b1);
      for (int j = 0; j < 8; j++) ch[j] = tx_hist[base + 15 + j * 10];
      chk($sformatf("%s_char%0d", tag, c), {23'd0, ok, ch}, {23'd0, 1'b1, exp[c]});
    end
    chk({tag, "_ack_latency"}, ack_k, exp_ack);
    chk({tag, "_ack_count"}, ack_cnt, 32'd1);
    chk({tag, "_busy_fall"}, busy_fall_k, (req_drop_k < 0) ? -1 : req_drop_k + 1);
    lows = 0;
    if (ack_k > 0) begin
      for (int k = ack_k; k < HMAX; k++) if (tx_hist[k] !== 1'b1) lows++;
    end
    chk({tag, "_no_retransmit"}, lows, 32'd0);
  endtask

  initial begin
    int t0_a, ack_a, lows, acks, gap;

    vecs[0] = '{typ: 1'b0, din: 32'h0000_0041, change_at: -1, din2: 32'd0, hold: 1,
                nchar: 1, exp: {8'h41, 64'd0}, exp_ack: 102};
    vecs[1] = '{typ: 1'b1, din: 32'h1234_ABCD, change_at: -1, din2: 32'd0, hold: 1,
                nchar: WCH, exp: {"1234ABCD", 8'h20}, exp_ack: 2 + WCH * 100};
    vecs[2] = '{typ: 1'b1, din: 32'h0000_0000, change_at: 50, din2: 32'hFFFF_FFFF, hold: 1,
                nchar: WCH, exp: {"00000000", 8'h20}, exp_ack: 2 + WCH * 100};
    vecs[3] = '{typ: 1'b0, din: 32'hFFFF_FF55, change_at: -1, din2: 32'd0, hold: 4,
                nchar: 1, exp: {8'h55, 64'd0}, exp_ack: 102};
    vecs[4] = '{typ: 1'b1, din: 32'hFEDC_0987, change_at: -1, din2: 32'd0, hold: 1,
                nchar: WCH, exp: {"FEDC0987", 8'h20}, exp_ack: 2 + WCH * 100};

    rst = 1'b1; req_tx = 1'b0; type_tx = 1'b0; din_tx = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ack", {31'd0, ack_tx}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      do_xfer(vecs[v].typ, vecs[v].din, vecs[v].change_at, vecs[v].din2, vecs[v].hold, 30);
      verify($sformatf("vec%0d", v), vecs[v].nchar, vecs[v].exp, vecs[v].exp_ack);
    end

    // Reset in the middle of a word (char 3, data bit 3 of '0' is low).
    type_tx = 1'b1; din_tx = 32'h0000_0000; req_tx = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 350; k++) begin
      @(posedge clk);
      #1;
    end
    chk("midword_tx_low", {31'd0, tx}, 32'd0);
    rst = 1'b1; req_tx = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ack", {31'd0, ack_tx}, 32'd0);
    rst = 1'b0;
    lows = 0; acks = 0;
    for (int k = 0; k < 700; k++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lows++;
      if (ack_tx !== 1'b0) acks++;
    end
    $display("[TB] xfer reset mid-word: lows=%0d acks=%0d after reset", lows, acks);
    chk("midrst_line_quiet", lows, 32'd0);
    chk("midrst_no_ack", acks, 32'd0);
    do_xfer(1'b0, 32'h0000_000D, -1, 32'd0, 1, 5);
    verify("after_rst", 1, {8'h0D, 64'd0}, 102);

    // Back-to-back bytes at minimum turnaround.
    do_xfer(1'b0, 32'h0000_000D, -1, 32'd0, 1, 0);
    verify("seq_cr", 1, {8'h0D, 64'd0}, 102);
    t0_a  = t0_abs;
    ack_a = ack_k;
    do_xfer(1'b0, 32'h0000_000A, -1, 32'd0, 1, 5);
    verify("seq_lf", 1, {8'h0A, 64'd0}, 102);
    gap = (t0_abs + first_low_k) - (t0_a + ack_a);
    chk("seq_idle_gap_ge2", {31'd0, (gap >= 2)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
